// File: rtl/bcd_display_scan.sv
// 4-digit multiplexed 7-segment driver for packed BCD results.
// Latches the BCD word on bcd_ready, scans one digit per REFRESH_DIV cycles,
// blanks leading zeros and shows dashes when any latched nibble is not decimal.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV   = 27000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_code,
  input  logic        bcd_ready,
  input  logic        display_en,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        bcd_err
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ERROR
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [15:0]    r_value;
  logic           r_have_data;
  logic [PW-1:0]  r_presc;
  logic [1:0]     r_digit;
  logic [3:0]     r_anodes;
  logic [6:0]     r_segments;
  logic           r_bcd_err;

  logic [3:0]     w_nib [4];
  logic           w_nib_bad;
  logic           w_tick;
  logic [3:0]     w_blank;
  logic [3:0]     w_cur_nib;
  logic [3:0]     w_anodes_nxt;
  logic [6:0]     w_segments_nxt;

  // Active-low gfedcba patterns for decimal digits.
  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Split the latched word into digits and derive error/blanking flags.
  always_comb begin
    w_nib[0]  = r_value[3:0];
    w_nib[1]  = r_value[7:4];
    w_nib[2]  = r_value[11:8];
    w_nib[3]  = r_value[15:12];
    w_nib_bad = (w_nib[0] > 4'd9) || (w_nib[1] > 4'd9) ||
                (w_nib[2] > 4'd9) || (w_nib[3] > 4'd9);
    w_blank    = '0;
    w_blank[3] = BLANK_LEADING && (w_nib[3] == 4'd0);
    w_blank[2] = w_blank[3] && (w_nib[2] == 4'd0);
    w_blank[1] = w_blank[2] && (w_nib[1] == 4'd0);
    w_tick     = (r_presc == PRESC_MAX);
    w_cur_nib  = w_nib[r_digit];
  end

  // Capture the converter result whenever it is flagged ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value     <= '0;
      r_have_data <= 1'b0;
    end else if (bcd_ready) begin
      r_value     <= bcd_code;
      r_have_data <= 1'b1;
    end
  end

  // Error flag follows the latched value by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_bcd_err <= 1'b0;
    else       r_bcd_err <= w_nib_bad;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; disabling the display overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (!display_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_have_data) w_state_nxt = w_nib_bad ? ST_ERROR : ST_SCAN;
        end
        ST_SCAN, ST_ERROR: begin
          w_state_nxt = w_nib_bad ? ST_ERROR : ST_SCAN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Slot prescaler and digit index; both run only while scanning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (!display_en) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (r_state != ST_IDLE) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_digit <= r_digit + 2'd1;
    end
  end

  // Output pattern for the current slot. display_en is folded in so the
  // digits go dark on the first edge after it drops, not one state later.
  always_comb begin
    w_anodes_nxt   = '1;
    w_segments_nxt = SEG_DARK;
    if (display_en) begin
      case (r_state)
        ST_SCAN: begin
          if (!w_blank[r_digit]) begin
            w_anodes_nxt   = ~(4'b0001 << r_digit);
            w_segments_nxt = f_decode(w_cur_nib);
          end
        end
        ST_ERROR: begin
          w_anodes_nxt   = ~(4'b0001 << r_digit);
          w_segments_nxt = SEG_DASH;
        end
        default: begin
          w_anodes_nxt   = '1;
          w_segments_nxt = SEG_DARK;
        end
      endcase
    end
  end

  // Registered display drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anodes   <= '1;
      r_segments <= SEG_DARK;
    end else begin
      r_anodes   <= w_anodes_nxt;
      r_segments <= w_segments_nxt;
    end
  end

  assign anodes   = r_anodes;
  assign segments = r_segments;
  assign bcd_err  = r_bcd_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4; a second instance
// with leading-zero blanking disabled shares the same stimulus.
module tb_bcd_display_scan;

  localparam int unsigned RD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_code;
  logic        bcd_ready;
  logic        display_en;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        err_a, err_b;

  int total;
  int bad;

  bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bcd_code(bcd_code), .bcd_ready(bcd_ready),
    .display_en(display_en), .anodes(an_a), .segments(seg_a), .bcd_err(err_a)
  );

  bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bcd_code(bcd_code), .bcd_ready(bcd_ready),
    .display_en(display_en), .anodes(an_b), .segments(seg_b), .bcd_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [27:0] sa;   // {d3,d2,d1,d0} expected segments, blanking on
    logic [27:0] sb;   // same, blanking off
    logic        err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input logic [6:0] seg, input int unsigned d);
    logic [3:0] one;
    one = 4'b0001 << d;
    return (seg == 7'h7F) ? 4'hF : ~one;
  endfunction

  task automatic chk_dark(input string name);
    chk({name, "_an_a"},  {12'd0, an_a},  16'h000F);
    chk({name, "_seg_a"}, {9'd0, seg_a},  16'h007F);
    chk({name, "_err_a"}, {15'd0, err_a}, 16'h0000);
    chk({name, "_an_b"},  {12'd0, an_b},  16'h000F);
    chk({name, "_seg_b"}, {9'd0, seg_b},  16'h007F);
  endtask

  // Capture a code with the display off, then re-enable so the scan starts at digit 0.
  task automatic load(input logic [15:0] code);
    @(negedge clk);
    display_en = 1'b0;
    bcd_code   = code;
    bcd_ready  = 1'b1;
    @(negedge clk);
    bcd_ready  = 1'b0;
    display_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] es;
    int unsigned d;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bcd_code = '0;
    bcd_ready = 1'b0;
    display_en = 1'b0;

    //             code      d3    d2    d1    d0 (blank on)   (blank off)                 err
    vt[0] = '{16'h1234, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 1'b0};
    vt[1] = '{16'h0007, {7'h7F,7'h7F,7'h7F,7'h78}, {7'h40,7'h40,7'h40,7'h78}, 1'b0};
    vt[2] = '{16'h0000, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}, 1'b0};
    vt[3] = '{16'h12A4, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b1};
    vt[4] = '{16'h0099, {7'h7F,7'h7F,7'h10,7'h10}, {7'h40,7'h40,7'h10,7'h10}, 1'b0};
    vt[5] = '{16'h0809, {7'h7F,7'h00,7'h40,7'h10}, {7'h40,7'h00,7'h40,7'h10}, 1'b0};
    vt[6] = '{16'h9876, {7'h10,7'h00,7'h78,7'h02}, {7'h10,7'h00,7'h78,7'h02}, 1'b0};
    vt[7] = '{16'hF000, {7'h3F,7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b1};
    vt[8] = '{16'h5000, {7'h12,7'h40,7'h40,7'h40}, {7'h12,7'h40,7'h40,7'h40}, 1'b0};

    repeat (3) @(negedge clk);
    chk_dark("reset");
    reset = 1'b0;
    display_en = 1'b1;

    // Enabled but nothing captured: stays dark.
    repeat (100) begin
      @(negedge clk);
      chk_dark("idle");
    end

    // Table: four full slots of four cycles each.
    for (int v = 0; v < 9; v++) begin
      load(vt[v].code);
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        d  = j / 4;
        es = vt[v].sa[d*7 +: 7];
        chk($sformatf("v%0d_j%0d_seg_a", v, j), {9'd0, seg_a}, {9'd0, es});
        chk($sformatf("v%0d_j%0d_an_a", v, j), {12'd0, an_a}, {12'd0, exp_an(es, d)});
        es = vt[v].sb[d*7 +: 7];
        chk($sformatf("v%0d_j%0d_seg_b", v, j), {9'd0, seg_b}, {9'd0, es});
        chk($sformatf("v%0d_j%0d_an_b", v, j), {12'd0, an_b}, {12'd0, exp_an(es, d)});
        chk($sformatf("v%0d_j%0d_err", v, j), {15'd0, err_a}, {15'd0, vt[v].err});
        chk($sformatf("v%0d_j%0d_onehot", v, j), 16'($countones(~an_a) <= 1), 16'd1);
      end
    end

    // Disable during digit 2, re-enable: restart at digit 0 with held value.
    load(16'h1234);
    repeat (9) @(negedge clk);
    chk("en_pre_an", {12'd0, an_a}, 16'h000B);
    display_en = 1'b0;
    @(negedge clk);
    chk_dark("en_off");
    repeat (5) @(negedge clk);
    chk_dark("en_off_hold");
    display_en = 1'b1;
    @(negedge clk);
    chk_dark("en_on_first");
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("en_on_d0_%0d_an", j), {12'd0, an_a}, 16'h000E);
      chk($sformatf("en_on_d0_%0d_seg", j), {9'd0, seg_a}, 16'h0019);
    end
    @(negedge clk);
    chk("en_on_d1_an", {12'd0, an_a}, 16'h000D);
    chk("en_on_d1_seg", {9'd0, seg_a}, 16'h0030);

    // Capture mid-slot: new digit value appears without disturbing the slot.
    load(16'h1234);
    @(negedge clk);
    bcd_code  = 16'h5678;
    bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
    chk("mid_old_seg", {9'd0, seg_a}, 16'h0019);
    @(negedge clk);
    chk("mid_new_seg", {9'd0, seg_a}, 16'h0000);
    chk("mid_new_an", {12'd0, an_a}, 16'h000E);
    @(negedge clk);
    chk("mid_new_seg2", {9'd0, seg_a}, 16'h0000);
    @(negedge clk);
    chk("mid_d1_seg", {9'd0, seg_a}, 16'h0078);
    chk("mid_d1_an", {12'd0, an_a}, 16'h000D);

    // Error flag timing while already scanning, then recovery.
    @(negedge clk);
    bcd_code  = 16'h12A4;
    bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
    chk("err_lat1", {15'd0, err_a}, 16'h0000);
    @(negedge clk);
    chk("err_lat2", {15'd0, err_a}, 16'h0001);
    @(negedge clk);
    chk("err_dash", {9'd0, seg_a}, 16'h003F);
    chk("err_onehot", 16'($countones(~an_a)), 16'd1);
    bcd_code  = 16'h0099;
    bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
    chk("clr_lat1", {15'd0, err_a}, 16'h0001);
    @(negedge clk);
    chk("clr_lat2", {15'd0, err_a}, 16'h0000);
    @(negedge clk);
    chk("clr_nodash", 16'(seg_a == 7'h3F), 16'd0);

    // Asynchronous reset mid-slot while showing an error.
    load(16'h12A4);
    repeat (2) @(negedge clk);
    chk("pre_rst_err", {15'd0, err_a}, 16'h0001);
    #2 reset = 1'b1;
    #1 chk_dark("async_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk_dark("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Drives the 4-digit multiplexed 7-segment display with the multiplier result. It sits directly downstream of the binary-to-BCD converter. It latches the packed 4-digit BCD code whenever the converter flags ready, then time-multiplexes the digits onto shared active-low segment lines with one active-low anode per digit. It also blanks leading zeros and flags non-decimal nibbles as an error display.

Parameters:
REFRESH_DIV, 27000, clk cycles each digit stays lit (27 MHz -> ~1 kHz per digit); legal range >= 2.
BLANK_LEADING, 1, 1 = suppress leading zeros on digits 3..1; 0 = always show all four digits.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
bcd_code  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
bcd_ready  input  1  level; bcd_code is valid in every cycle this is high
display_en  input  1  1 = scan display; 0 = all digits dark
anodes  output  4  active-low digit enables; bit k = digit k (digit 0 = units)
segments  output  7  active-low segments, order {g,f,e,d,c,b,a}
bcd_err  output  1  high while the latched value contains a nibble > 9

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: anodes=4'b1111, segments=7'h7F, bcd_err=0, value_reg=0, have_data=0, prescaler=0, digit_idx=0, state=IDLE.
- Capture: on every rising clk edge with bcd_ready=1, value_reg<=bcd_code and have_data<=1. Capture also occurs while display_en=0.
- nib_bad: combinational; high when any nibble of value_reg is > 9. bcd_err is registered as nib_bad, one cycle after value_reg.
- Prescaler: counts 0..REFRESH_DIV-1 in SCAN/ERROR and wraps to 0. tick = (prescaler==REFRESH_DIV-1).
- digit_idx: increments on tick, wraps 3->0.
- FSM states: IDLE, SCAN, ERROR.
  - IDLE -> SCAN when display_en & have_data & !nib_bad.
  - IDLE -> ERROR when display_en & have_data & nib_bad.
  - SCAN <-> ERROR re-evaluated every cycle from nib_bad.
  - Any state -> IDLE when display_en=0. This has priority, and clears prescaler and digit_idx to 0.
- Output register: anodes and segments are registered every cycle from (state, digit_idx, value_reg).
  - Latency: 1 cycle from a digit_idx/state change; 2 cycles from bcd_ready to the display.
- IDLE outputs: anodes=4'b1111, segments=7'h7F.
- SCAN outputs: anodes = one-hot-low at digit_idx; segments = decode of nibble[digit_idx].
- Leading-zero blanking (BLANK_LEADING=1): digit k (k=3,2,1) is blanked if it and all higher digits are 0. Digit 0 is never blanked.
  - A blanked slot keeps its time slot (prescaler runs) but outputs anodes=4'b1111, segments=7'h7F.
- ERROR outputs: every digit shows dash (7'h3F) with its anode asserted; there is no blanking.
- Decode (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex values)
- A new capture mid-slot takes effect on the next output register update; prescaler and digit_idx are not disturbed.
- Glitch rule: never more than one anode low in any cycle.

Test Plan:
1. Reset, then no bcd_ready for 100 cycles -> anodes=1111, segments=7F, bcd_err=0 throughout.
2. REFRESH_DIV=4, display_en=1, bcd_code=16'h1234, bcd_ready pulse -> expected output sequence, each slot 4 cycles, repeating:
   - anodes 1110/seg 19
   - anodes 1101/seg 30
   - anodes 1011/seg 24
   - anodes 0111/seg 79
3. bcd_code=16'h0007 -> digit0 slot: 1110/78; digit1-3 slots: 1111/7F. Then bcd_code=16'h0000 -> digit0 slot 1110/40, others dark. With BLANK_LEADING=0, 16'h0007 shows 40 on digits 1-3.
4. bcd_code=16'h12A4 -> bcd_err=1 two cycles after bcd_ready; every slot shows its anode with seg 3F. Then bcd_code=16'h0099 -> bcd_err=0 and scan resumes showing 99.
5. Deassert display_en during digit2 slot -> next cycle anodes=1111. Reassert -> scan restarts at digit0 with a full 4-cycle slot, and value_reg still holds the last capture.
6. Assert reset asynchronously mid-slot -> anodes=1111, segments=7F, bcd_err=0 immediately, without waiting for a clk edge. After release, the display stays dark until a new bcd_ready.
